// File: rtl/pipelined_addsub_pkg.sv
// Shared defaults and the slice-add primitive for the carry-pipelined add/subtract unit.
package pipelined_addsub_pkg;

    localparam int WIDTH_DEF  = 16;
    localparam int STAGES_DEF = 4;
    localparam int ADD_MAXW   = 64;

    // Operands arrive zero-extended, so for an n-bit slice bit n of the result is the carry
    // and bits n-1:0 are the sum: truncating to n+1 bits yields {carry, sum}.
    function automatic logic [ADD_MAXW:0] slice_add(input logic [ADD_MAXW-1:0] a,
                                                    input logic [ADD_MAXW-1:0] b,
                                                    input logic                cin);
        return {1'b0, a} + {1'b0, b} + {{ADD_MAXW{1'b0}}, cin};
    endfunction

endpackage

// File: rtl/pipelined_addsub_if.sv
// Producer/consumer handshake bundle for pipelined_addsub: operand side and result side.
interface pipelined_addsub_if
    import pipelined_addsub_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] S;
    logic             Cout;
    logic             ovf;

    modport master (
        output in_valid, A, B, sub, out_ready,
        input  in_ready, out_valid, S, Cout, ovf
    );

    modport slave (
        input  in_valid, A, B, sub, out_ready,
        output in_ready, out_valid, S, Cout, ovf
    );
endinterface

// File: rtl/pipelined_addsub_slice.sv
// Combinational SLICE-bit adder with carry in/out, one instance per pipeline stage.
module addsub_slice
    import pipelined_addsub_pkg::*;
#(
    parameter int SLICE = 4
) (
    input  logic [SLICE-1:0] a_i,
    input  logic [SLICE-1:0] b_i,
    input  logic             cin_i,
    output logic [SLICE-1:0] sum_o,
    output logic             cout_o
);
    assign {cout_o, sum_o} = (SLICE+1)'(slice_add(ADD_MAXW'(a_i), ADD_MAXW'(b_i), cin_i));
endmodule

// File: rtl/pipelined_addsub.sv
// N-stage carry-pipelined adder, one WIDTH/STAGES-bit slice per stage, valid/ready on both sides.
// Build with ADDSUB_EN defined to honour the per-transaction sub bit (A-B); otherwise it always adds.
module pipelined_addsub
    import pipelined_addsub_pkg::*;
#(
    parameter int WIDTH  = WIDTH_DEF,
    parameter int STAGES = STAGES_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    pipelined_addsub_if.slave bus
);
    localparam int SLICE = WIDTH / STAGES;

    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] result;
        logic             sub;
        logic             carry;
        logic             msb_cin;
        logic             valid;
    } stage_t;

    stage_t            stage_q  [STAGES];
    stage_t            stage_d  [STAGES];
    stage_t            stage_in [STAGES];
    logic [SLICE-1:0]  sum_w    [STAGES];
    logic [SLICE-1:0]  beff_w   [STAGES];
    logic              cout_w   [STAGES];
    logic [STAGES-1:0] adv;
    logic              in_ready_w;

    // A stage may advance when it is empty or its successor advances.
    always_comb begin
        logic adv_next;
        adv      = '0;
        adv_next = bus.out_ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            adv[k]   = !stage_q[k].valid | adv_next;
            adv_next = adv[k];
        end
    end

    assign in_ready_w   = adv[0] & !flush;
    assign bus.in_ready = in_ready_w;

    // The sub bit is folded into the stage-0 carry-in and rides with the record.
    always_comb begin
        stage_in[0]       = '0;
        stage_in[0].a     = bus.A;
        stage_in[0].b     = bus.B;
`ifdef ADDSUB_EN
        stage_in[0].sub   = bus.sub;
        stage_in[0].carry = bus.sub;
`endif
        stage_in[0].valid = bus.in_valid & in_ready_w;
        for (int k = 1; k < STAGES; k++) begin
            stage_in[k] = stage_q[k-1];
        end
    end

`ifndef ADDSUB_EN
    logic unused_sub;
    assign unused_sub = bus.sub;
`endif

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
`ifdef ADDSUB_EN
        assign beff_w[k] = stage_in[k].sub ? ~stage_in[k].b[k*SLICE +: SLICE]
                                           :  stage_in[k].b[k*SLICE +: SLICE];
`else
        assign beff_w[k] = stage_in[k].b[k*SLICE +: SLICE];
`endif
        addsub_slice #(.SLICE(SLICE)) u_slice (
            .a_i    (stage_in[k].a[k*SLICE +: SLICE]),
            .b_i    (beff_w[k]),
            .cin_i  (stage_in[k].carry),
            .sum_o  (sum_w[k]),
            .cout_o (cout_w[k])
        );
    end

    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            stage_d[k] = stage_q[k];
            if (adv[k]) begin
                stage_d[k]                         = stage_in[k];
                stage_d[k].result[k*SLICE +: SLICE] = sum_w[k];
                stage_d[k].carry                   = cout_w[k];
                stage_d[k].msb_cin                 = stage_in[k].a[k*SLICE+SLICE-1]
                                                     ^ beff_w[k][SLICE-1]
                                                     ^ sum_w[k][SLICE-1];
            end
            if (flush) begin
                stage_d[k].valid = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < STAGES; k++) begin
            if (reset) begin
                stage_q[k] <= '0;
            end else begin
                stage_q[k] <= stage_d[k];
            end
        end
    end

    assign bus.out_valid = stage_q[STAGES-1].valid;
    assign bus.S         = stage_q[STAGES-1].result;
    assign bus.Cout      = stage_q[STAGES-1].carry;
    assign bus.ovf       = stage_q[STAGES-1].msb_cin ^ stage_q[STAGES-1].carry;
endmodule

// File: tb/tb_pipelined_addsub.sv
// Directed bench for pipelined_addsub (WIDTH=16, STAGES=4): reset, carry ripple, add/sub, streaming,
// backpressure and flush, each against hand-computed results.
module tb_pipelined_addsub;

    logic clk = 1'b0;
    logic reset;
    logic flush;

    always #5 clk = ~clk;

    pipelined_addsub_if #(.WIDTH(16)) bus ();

    pipelined_addsub #(.WIDTH(16), .STAGES(4)) dut (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .bus   (bus)
    );

    int          n_tests    = 0;
    int          n_fail     = 0;
    int          cyc        = 0;
    int          valid_seen = 0;
    logic [15:0] res_s   [$];
    logic        res_c   [$];
    logic        res_o   [$];
    int          res_cyc [$];
    int          acc_cyc [$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!reset) begin
            if (bus.in_valid && bus.in_ready) acc_cyc.push_back(cyc);
            if (bus.out_valid) valid_seen++;
            if (bus.out_valid && bus.out_ready) begin
                res_s.push_back(bus.S);
                res_c.push_back(bus.Cout);
                res_o.push_back(bus.ovf);
                res_cyc.push_back(cyc);
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_q();
        res_s.delete();
        res_c.delete();
        res_o.delete();
        res_cyc.delete();
        acc_cyc.delete();
    endtask

    task automatic send(input logic [15:0] a, input logic [15:0] b, input logic s);
        bit ok;
        ok           = 1'b0;
        bus.in_valid = 1'b1;
        bus.A        = a;
        bus.B        = b;
        bus.sub      = s;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (ok) begin
            @(posedge clk);
            #1;
        end else begin
            check("send_timeout", 32'(ok), 32'd1);
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_res(input int n);
        for (int t = 0; t < 200 && res_s.size() < n; t++) @(posedge clk);
        #1;
        check("wait_res", 32'(res_s.size()), 32'(n));
    endtask

    initial begin
        int acc;
        int v0;
        bit took;

        reset         = 1'b1;
        flush         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.A         = '0;
        bus.B         = '0;
        bus.sub       = 1'b0;
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_S",         32'(bus.S),         32'h0000);
        check("rst_Cout",      32'(bus.Cout),      32'd0);
        check("rst_ovf",       32'(bus.ovf),       32'd0);
        check("rst_in_ready",  32'(bus.in_ready),  32'd1);

        clear_q();
        send(16'hFFFF, 16'h0001, 1'b0);
        send(16'h7FFF, 16'h0001, 1'b0);
        wait_res(2);
        check("ripple_S0",    32'(res_s[0]), 32'h0000);
        check("ripple_Cout0", 32'(res_c[0]), 32'd1);
        check("ripple_ovf0",  32'(res_o[0]), 32'd0);
        check("ripple_S1",    32'(res_s[1]), 32'h8000);
        check("ripple_Cout1", 32'(res_c[1]), 32'd0);
        check("ripple_ovf1",  32'(res_o[1]), 32'd1);
        check("ripple_lat",   32'(res_cyc[0] - acc_cyc[0]), 32'd4);

        clear_q();
        send(16'h0005, 16'h0007, 1'b1);
        send(16'h8000, 16'h0001, 1'b1);
        wait_res(2);
`ifdef ADDSUB_EN
        check("sub_S0",    32'(res_s[0]), 32'hFFFE);
        check("sub_Cout0", 32'(res_c[0]), 32'd0);
        check("sub_ovf0",  32'(res_o[0]), 32'd0);
        check("sub_S1",    32'(res_s[1]), 32'h7FFF);
        check("sub_Cout1", 32'(res_c[1]), 32'd1);
        check("sub_ovf1",  32'(res_o[1]), 32'd1);
`else
        check("add_S0",    32'(res_s[0]), 32'h000C);
        check("add_Cout0", 32'(res_c[0]), 32'd0);
        check("add_ovf0",  32'(res_o[0]), 32'd0);
        check("add_S1",    32'(res_s[1]), 32'h8001);
        check("add_Cout1", 32'(res_c[1]), 32'd0);
        check("add_ovf1",  32'(res_o[1]), 32'd0);
`endif

        clear_q();
        for (int i = 0; i < 8; i++) send(16'(i * 32'h1111), 16'h0101, 1'b0);
        wait_res(8);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("stream_S%0d", i), 32'(res_s[i]), 32'(16'(i * 32'h1111 + 32'h0101)));
        end
        check("stream_lat", 32'(res_cyc[0] - acc_cyc[0]), 32'd4);
        check("stream_gap", 32'(res_cyc[7] - res_cyc[0]), 32'd7);

        clear_q();
        bus.out_ready = 1'b0;
        acc = 0;
        for (int t = 0; t < 8; t++) begin
            bus.in_valid = 1'b1;
            bus.A        = 16'(32'h1000 * (acc + 1));
            bus.B        = 16'(acc);
            bus.sub      = 1'b0;
            @(negedge clk);
            took = bus.in_ready;
            @(posedge clk);
            #1;
            if (took) acc++;
        end
        check("bp_accepted", 32'(acc), 32'd4);
        @(negedge clk);
        check("bp_in_ready", 32'(bus.in_ready),  32'd0);
        check("bp_valid",    32'(bus.out_valid), 32'd1);
        check("bp_hold_S_a", 32'(bus.S),         32'h1000);
        repeat (3) @(negedge clk);
        check("bp_hold_S_b", 32'(bus.S),         32'h1000);
        check("bp_hold_vld", 32'(bus.out_valid), 32'd1);
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
        for (int t = 0; t < 20 && acc < 6; t++) begin
            bus.in_valid = 1'b1;
            bus.A        = 16'(32'h1000 * (acc + 1));
            bus.B        = 16'(acc);
            @(negedge clk);
            took = bus.in_ready;
            @(posedge clk);
            #1;
            if (took) acc++;
        end
        bus.in_valid = 1'b0;
        check("bp_total", 32'(acc), 32'd6);
        wait_res(6);
        for (int i = 0; i < 6; i++) begin
            check($sformatf("bp_S%0d", i), 32'(res_s[i]), 32'(16'(32'h1000 * (i + 1) + i)));
        end

        repeat (6) @(posedge clk);
        #1;
        clear_q();
        v0 = valid_seen;
        send(16'h1111, 16'h2222, 1'b0);
        send(16'h3333, 16'h4444, 1'b0);
        flush = 1'b1;
        @(negedge clk);
        check("flush_in_ready", 32'(bus.in_ready), 32'd0);
        @(posedge clk);
        #1 flush = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        check("flush_no_valid",  32'(valid_seen - v0), 32'd0);
        check("flush_no_result", 32'(res_s.size()),    32'd0);
        clear_q();
        send(16'h0A0A, 16'h0101, 1'b0);
        wait_res(1);
        check("post_flush_S",   32'(res_s[0]), 32'h0B0B);
        check("post_flush_lat", 32'(res_cyc[0] - acc_cyc[0]), 32'd4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
